multiplexer_2to1: RTL and testbench
===================================

Name: multiplexer_2to1

Overview:
- 2:1 data selector with a combinational output and a registered copy.
- sel=1 routes a, sel=0 routes b; note the polarity, a is selected by the high value.
- Used as a leaf selection cell in datapaths.
- The combinational path serves same-cycle consumers; the registered path serves timing-closed consumers one clock later.

Parameters:
- WIDTH, 1, bit width of a, b, out and out_q.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled only on the rising edge of clk.
- a  input  WIDTH  data input, selected when sel=1.
- b  input  WIDTH  data input, selected when sel=0.
- sel  input  1  select: 1 → a, 0 → b.
- en  input  1  load enable for the registered output.
- out  output  WIDTH  combinational selection result.
- out_q  output  WIDTH  registered selection result.
- out_q_valid  output  1  out_q holds a value loaded since reset.

Behaviour:
- out = sel ? a : b, purely combinational, zero latency.
  - out is unaffected by clk, rst_n and en.
- sel X/Z: out must not silently pick a; simulation yields X on out.
  - No synthesis-time priority is implied.
- Rising clk edge with rst_n=0:
  - out_q ← 0, out_q_valid ← 0.
  - Reset dominates en.
  - Reset mid-operation discards any held value on that edge.
- Rising clk edge with rst_n=1 and en=1:
  - out_q ← (sel ? a : b) as sampled at that edge, out_q_valid ← 1.
  - Latency is exactly 1 cycle.
- Rising clk edge with rst_n=1 and en=0:
  - out_q and out_q_valid hold.
- out_q_valid, once set, stays 1 until the next reset edge.
- Asserting rst_n low between edges has no effect until the next rising edge.
- a, b or sel changing between edges affects only out, never out_q, until the next enabled edge.
- All WIDTH bits are selected by the same sel; there is no per-bit selection.
- WIDTH must be ≥1.
- No handshake, no backpressure, no state machine.

Decomposition:
- Shared package multiplexer_pkg holds:
  - SEL_A = 1'b1, SEL_B = 1'b0.
  - DEFAULT_WIDTH = 1.
- One natural sub-module, mux2_cell:
  - Parameterised WIDTH, purely combinational sel ? a : b.
  - Instantiated once; drives both out and the D input of the out_q register.
- The register stage stays in the top.

Test Plan:
- Reset: rst_n=0 for 2 edges with en=1, a=1, b=1, sel=1 → out_q=0, out_q_valid=0 after each edge; out=1 throughout.
- Exhaustive combinational check, WIDTH=1, rst_n=1: drive all 8 (a,b,sel) combinations, 100 ns each, checking at mid-interval:
  - (0,0,0)→0, (0,0,1)→0, (0,1,0)→1, (0,1,1)→0.
  - (1,0,0)→0, (1,0,1)→1, (1,1,0)→1, (1,1,1)→1.
- Registered latency: en=1, a=1, b=0, sel toggles 1,0,1 on successive edges.
  - out_q shows 1,0,1 one edge later.
  - out_q_valid=1 from the first post-reset edge.
- Hold: load out_q=1, then en=0 and sel=0, b=0 for 3 edges → out_q stays 1, out stays 0.
- Reset mid-operation: out_q=1, out_q_valid=1, then rst_n=0 for one edge with en=1 → out_q=0, out_q_valid=0; resumes loading when rst_n=1.
- WIDTH=8: a=0xA5, b=0x3C:
  - sel=1 → out=0xA5; sel=0 → out=0x3C.
  - out_q follows one enabled edge later.

Source files
------------

// File: rtl/multiplexer_pkg.sv
// Shared constants for the 2:1 selector: select encodings and the default data width.
package multiplexer_pkg;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/mux2_cell.sv
// Purely combinational WIDTH-bit 2:1 selector; one sel steers every bit.
module mux2_cell
  import multiplexer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // An X/Z sel makes the equality X, so the ternary merges a and b instead of favouring a.
  assign y = (sel == SEL_A) ? a : b;

endmodule

// File: rtl/multiplexer_2to1.sv
// 2:1 selector with a zero-latency output and an enable-loaded registered copy.
module multiplexer_2to1
  import multiplexer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_q_valid
);

  logic [WIDTH-1:0] sel_y;
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  mux2_cell #(.WIDTH(WIDTH)) u_cell (
    .a  (a),
    .b  (b),
    .sel(sel),
    .y  (sel_y)
  );

  // No handshake: en is a plain load strobe, and valid only records that a load happened since reset.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (en) begin
      data_d  = sel_y;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out         = sel_y;
  assign out_q       = data_q;
  assign out_q_valid = valid_q;

endmodule

// File: tb/tb_multiplexer_2to1.sv
// Self-checking bench for multiplexer_2to1 at WIDTH=1 and WIDTH=8.
module tb_multiplexer_2to1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sel;
  logic       a1, b1;
  logic [7:0] a8, b8;
  logic       out1, out_q1, vld1;
  logic [7:0] out8, out_q8;
  logic       vld8;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  // Scoreboard entry: {valid1, data1, valid8, data8}
  logic [10:0] exp_q[$];
  logic        m_v1, m_d1, m_v8;
  logic [7:0]  m_d8;

  multiplexer_2to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel), .en(en),
    .out(out1), .out_q(out_q1), .out_q_valid(vld1)
  );

  multiplexer_2to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel), .en(en),
    .out(out8), .out_q(out_q8), .out_q_valid(vld8)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Driver: new inputs land just after a falling edge and are sampled on the next rising edge.
  task automatic step(input logic r, input logic e, input logic s,
                      input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    #1;
    rst_n = r;
    en    = e;
    sel   = s;
    a1    = av[0];
    b1    = bv[0];
    a8    = av;
    b8    = bv;
  endtask

  // Scoreboard: predict at each rising edge, compare after it.
  always @(posedge clk) begin
    if (!done) begin
      if (!rst_n) begin
        m_d1 = 1'b0; m_v1 = 1'b0; m_d8 = 8'h00; m_v8 = 1'b0;
      end else if (en) begin
        m_d1 = sel ? a1 : b1;
        m_d8 = sel ? a8 : b8;
        m_v1 = 1'b1;
        m_v8 = 1'b1;
      end
      exp_q.push_back({m_v1, m_d1, m_v8, m_d8});
    end
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_q_w1",  {31'd0, out_q1}, {31'd0, e[9]});
      check("valid_w1",  {31'd0, vld1},   {31'd0, e[10]});
      check("out_q_w8",  {24'd0, out_q8}, {24'd0, e[7:0]});
      check("valid_w8",  {31'd0, vld8},   {31'd0, e[8]});
    end
  end

  initial begin
    logic [7:0] comb_tbl;
    logic [7:0] ra, rb;
    comb_tbl = 8'b1110_0100;  // indexed by {a,b,sel}
    rst_n = 1'b0; en = 1'b1; sel = 1'b1;
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;

    // Reset for two edges with en=1; out stays 1 throughout
    #2 check("reset_out_w1", {31'd0, out1}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 8'h01, 8'h01);
    #2 check("reset_out_w1", {31'd0, out1}, 32'd1);
    @(posedge clk); #1;
    check("reset_out_q", {31'd0, out_q1}, 32'd0);
    check("reset_valid", {31'd0, vld1}, 32'd0);

    // Exhaustive combinational table, en=0 so the register keeps its reset value
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = i[2:0];
      step(1'b1, 1'b0, idx[0], {7'd0, idx[2]}, {7'd0, idx[1]});
      #49;
      check($sformatf("comb_%0d", i), {31'd0, out1}, {31'd0, comb_tbl[idx]});
      #50;
    end

    // Registered latency: sel 1,0,1 with a=1, b=0
    step(1'b1, 1'b1, 1'b1, 8'h01, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h01, 8'h00);
    @(posedge clk); #1;
    check("latency_out_q", {31'd0, out_q1}, 32'd1);
    check("latency_valid", {31'd0, vld1}, 32'd1);

    // Hold: en=0, sel=0, b=0 for 3 edges
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
      #2 check("hold_out", {31'd0, out1}, 32'd0);
    end
    @(posedge clk); #1;
    check("hold_out_q", {31'd0, out_q1}, 32'd1);

    // Reset mid-operation with en=1, then resume loading
    step(1'b0, 1'b1, 1'b1, 8'h01, 8'h00);
    @(posedge clk); #1;
    check("midrst_out_q", {31'd0, out_q1}, 32'd0);
    check("midrst_valid", {31'd0, vld1}, 32'd0);
    step(1'b1, 1'b1, 1'b1, 8'h01, 8'h00);
    @(posedge clk); #1;
    check("resume_out_q", {31'd0, out_q1}, 32'd1);
    check("resume_valid", {31'd0, vld1}, 32'd1);

    // WIDTH=8 patterns
    step(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C);
    #2 check("w8_sel1_out", {24'd0, out8}, 32'hA5);
    step(1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C);
    #2 check("w8_sel0_out", {24'd0, out8}, 32'h3C);
    @(posedge clk); #1;
    check("w8_out_q", {24'd0, out_q8}, 32'h3C);

    // Random traffic, occasional reset
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ra, rb);
      #2;
      check("rand_out_w8", {24'd0, out8}, {24'd0, (sel ? ra : rb)});
      check("rand_out_w1", {31'd0, out1}, {31'd0, (sel ? ra[0] : rb[0])});
    end

    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    done = 1'b1;
    @(negedge clk);
    #2;
    if (exp_q.size() != 0) check("sb_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
